instr_queue_reg: RTL and testbench

INSTR_QUEUE_REG -- requirements
Module: instr_queue_reg

---
 rtl/instr_queue_reg.sv | 140 ++++++++++++++
 tb/tb_instr_queue_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue_reg.sv
// ---------------------------------------------------------------------------
// instr_queue_reg
//   DEPTH-entry circular instruction queue. The head entry is decoded into
//   MIPS-style fields (Opcode, ReadReg1..3, Imm); all fields read zero while
//   no head entry is present. A push into a full queue is dropped and sets a
//   sticky Overflow flag that only Flush or Reset clears.
//
//   Optional feature macro: INSTR_QUEUE_BYPASS_EN
//     When defined, a push into an empty queue is presented at the head in the
//     same cycle straight from Instruction; if Advance is also high the word
//     is consumed without ever being stored. When undefined (default), no
//     combinational path exists from Instruction/IRWrite to any output.
// ---------------------------------------------------------------------------
module instr_queue_reg #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [31:0]   Instruction,
  input  logic          IRWrite,
  input  logic          Advance,
  input  logic          Flush,
  output logic [5:0]    Opcode,
  output logic [4:0]    ReadReg1,
  output logic [4:0]    ReadReg2,
  output logic [4:0]    ReadReg3,
  output logic [15:0]   Imm,
  output logic          Valid,
  output logic          Full,
  output logic [CW-1:0] Count,
  output logic          Overflow
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  // Storage and control state
  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Decoded handshake terms
  logic          w_stored_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_bypass;
  logic          w_consume;
  logic [31:0]   w_head_word;
  logic [31:0]   w_field_word;

  // Pointer increment with explicit wrap from the last entry back to zero.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_stored_valid = (r_count != '0);
  assign w_full         = (r_count == DEPTH_C);

`ifdef INSTR_QUEUE_BYPASS_EN
  // Empty queue with a push: the incoming word is the head this cycle.
  // Gated by Reset so every output is forced low while reset is asserted.
  assign w_bypass  = Reset && IRWrite && !w_stored_valid;
  // Bypassed word popped in the same cycle never enters storage.
  assign w_consume = w_bypass && Advance;
`else
  assign w_bypass  = 1'b0;
  assign w_consume = 1'b0;
`endif

  // Pop only retires a stored entry; Advance on an empty queue is ignored.
  assign w_pop  = Advance && w_stored_valid;
  // A full queue still accepts a push when the head retires in the same cycle.
  assign w_push = IRWrite && !w_consume && (!w_full || w_pop);
  // Dropped push: full and nothing leaves this cycle.
  assign w_drop = IRWrite && w_full && !Advance;

  // Pointer, occupancy and sticky-overflow state; Flush outranks push/pop.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (Flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage write port.
  // NOTE: the data array has no reset; stale words are never observable
  // because every read is qualified by Count, so clearing it buys nothing.
  always_ff @(posedge Clk) begin
    if (Reset && !Flush && w_push) begin
      r_mem[r_wr_ptr] <= Instruction;
    end
  end

  // Head selection and zero-masking of the decoded fields when no head exists.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal (no latches).
    w_head_word  = r_mem[r_rd_ptr];
    w_field_word = '0;
    if (w_bypass) w_head_word = Instruction;
    if (Valid)    w_field_word = w_head_word;
  end

  assign Valid    = w_stored_valid || w_bypass;
  assign Full     = w_full;
  assign Count    = r_count;
  assign Overflow = r_overflow;

  assign Opcode   = w_field_word[31:26];
  assign ReadReg1 = w_field_word[25:21];
  assign ReadReg2 = w_field_word[20:16];
  assign ReadReg3 = w_field_word[15:11];
  assign Imm      = w_field_word[15:0];

  // Occupancy can never exceed the number of entries.
  a_count_bound : assert property (@(posedge Clk) disable iff (!Reset) r_count <= DEPTH_C)
    else $error("instr_queue_reg: Count above DEPTH");

endmodule

// File: tb/tb_instr_queue_reg.sv
// ---------------------------------------------------------------------------
// tb_instr_queue_reg
//   Directed, table-driven bench for instr_queue_reg (DEPTH=4), plus
//   hand-written sequences for reset, full-queue streaming and flush.
// ---------------------------------------------------------------------------
module tb_instr_queue_reg;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instruction;
  logic        IRWrite;
  logic        Advance;
  logic        Flush;
  logic [5:0]  Opcode;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  ReadReg3;
  logic [15:0] Imm;
  logic        Valid;
  logic        Full;
  logic [2:0]  Count;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;

  instr_queue_reg #(.DEPTH(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Instruction(Instruction),
    .IRWrite    (IRWrite),
    .Advance    (Advance),
    .Flush      (Flush),
    .Opcode     (Opcode),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadReg3   (ReadReg3),
    .Imm        (Imm),
    .Valid      (Valid),
    .Full       (Full),
    .Count      (Count),
    .Overflow   (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        irw;
    logic        adv;
    logic        flush;
    logic [31:0] instr;
    logic        exp_valid;
    logic [2:0]  exp_count;
    logic        exp_full;
    logic        exp_ovf;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against an expected head word / status set.
  task automatic check_outputs(input string tag, input logic valid, input logic [2:0] count,
                               input logic full, input logic ovf, input logic [31:0] head);
    logic [31:0] w;
    w = valid ? head : 32'h0;
    check({tag, ".valid"},    32'(Valid),    32'(valid));
    check({tag, ".count"},    32'(Count),    32'(count));
    check({tag, ".full"},     32'(Full),     32'(full));
    check({tag, ".overflow"}, 32'(Overflow), 32'(ovf));
    check({tag, ".opcode"},   32'(Opcode),   32'(w[31:26]));
    check({tag, ".rr1"},      32'(ReadReg1), 32'(w[25:21]));
    check({tag, ".rr2"},      32'(ReadReg2), 32'(w[20:16]));
    check({tag, ".rr3"},      32'(ReadReg3), 32'(w[15:11]));
    check({tag, ".imm"},      32'(Imm),      32'(w[15:0]));
  endtask

  task automatic drive(input logic irw, input logic adv, input logic fl, input logic [31:0] instr);
    IRWrite     = irw;
    Advance     = adv;
    Flush       = fl;
    Instruction = instr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // One rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Apply one set of inputs for exactly one edge, then return inputs to idle.
  task automatic step(input logic irw, input logic adv, input logic fl, input logic [31:0] instr);
    drive(irw, adv, fl, instr);
    tick();
    idle();
  endtask

  initial begin
    localparam logic [31:0] W0 = 32'h8C22_0004;
    localparam logic [31:0] W1 = 32'h1111_1111;
    localparam logic [31:0] W2 = 32'h2222_2222;
    localparam logic [31:0] W3 = 32'h3333_3333;
    localparam logic [31:0] W4 = 32'h4444_4444;
    localparam logic [31:0] W5 = 32'hA5A5_A5A5;
    localparam logic [31:0] W6 = 32'h5A5A_5A5A;

    //              irw  adv  fl   instr  valid cnt   full ovf  head
    vecs[0]  = '{1'b1,1'b0,1'b0, W0,   1'b1, 3'd1, 1'b0,1'b0, W0};
    vecs[1]  = '{1'b1,1'b0,1'b0, W1,   1'b1, 3'd2, 1'b0,1'b0, W0};
    vecs[2]  = '{1'b1,1'b0,1'b0, W2,   1'b1, 3'd3, 1'b0,1'b0, W0};
    vecs[3]  = '{1'b1,1'b0,1'b0, W3,   1'b1, 3'd4, 1'b1,1'b0, W0};
    vecs[4]  = '{1'b1,1'b0,1'b0, W4,   1'b1, 3'd4, 1'b1,1'b1, W0};
    vecs[5]  = '{1'b0,1'b1,1'b0, 32'h0,1'b1, 3'd3, 1'b0,1'b1, W1};
    vecs[6]  = '{1'b0,1'b1,1'b0, 32'h0,1'b1, 3'd2, 1'b0,1'b1, W2};
    vecs[7]  = '{1'b0,1'b1,1'b0, 32'h0,1'b1, 3'd1, 1'b0,1'b1, W3};
    vecs[8]  = '{1'b0,1'b1,1'b0, 32'h0,1'b0, 3'd0, 1'b0,1'b1, 32'h0};
    vecs[9]  = '{1'b0,1'b1,1'b0, 32'h0,1'b0, 3'd0, 1'b0,1'b1, 32'h0};
    vecs[10] = '{1'b0,1'b0,1'b1, 32'h0,1'b0, 3'd0, 1'b0,1'b0, 32'h0};
    vecs[11] = '{1'b1,1'b0,1'b0, W5,   1'b1, 3'd1, 1'b0,1'b0, W5};
    vecs[12] = '{1'b1,1'b1,1'b0, W6,   1'b1, 3'd1, 1'b0,1'b0, W6};
    vecs[13] = '{1'b0,1'b1,1'b0, 32'h0,1'b0, 3'd0, 1'b0,1'b0, 32'h0};

    // ---- Reset state ----
    idle();
    Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_outputs("reset", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check_outputs("post_reset", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);

    // ---- Single push decode (lw-style word) ----
`ifndef INSTR_QUEUE_BYPASS_EN
    drive(1'b1, 1'b0, 1'b0, W0);
    #1;
    check("no_bypass.valid", 32'(Valid), 32'd0);
    check("no_bypass.opcode", 32'(Opcode), 32'd0);
    tick();
    idle();
`else
    step(1'b1, 1'b0, 1'b0, W0);
`endif
    check("decode.valid",  32'(Valid),    32'd1);
    check("decode.opcode", 32'(Opcode),   32'h23);
    check("decode.rr1",    32'(ReadReg1), 32'd1);
    check("decode.rr2",    32'(ReadReg2), 32'd2);
    check("decode.rr3",    32'(ReadReg3), 32'd0);
    check("decode.imm",    32'(Imm),      32'h0004);
    check("decode.count",  32'(Count),    32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check_outputs("decode_flush", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);

    // ---- Table: fill, overflow, drain, empty-advance, flush, push+pop ----
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].irw, vecs[i].adv, vecs[i].flush, vecs[i].instr);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_count,
                    vecs[i].exp_full, vecs[i].exp_ovf, vecs[i].exp_head);
    end

    // ---- Full queue streaming across pointer wrap ----
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'hB000_0000 + 32'(k));
    check_outputs("stream_fill", 1'b1, 3'd4, 1'b1, 1'b0, 32'hB000_0000);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'hB000_0004 + 32'(k));
      check_outputs($sformatf("stream%0d", k), 1'b1, 3'd4, 1'b1, 1'b0,
                    32'hB000_0001 + 32'(k));
    end

    // ---- Overflow then flush with simultaneous push/pop at Count=2 ----
    step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    check_outputs("ovf_set", 1'b1, 3'd4, 1'b1, 1'b1, 32'hB000_0008);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_outputs("ovf_sticky", 1'b1, 3'd2, 1'b0, 1'b1, 32'hB000_000A);
    step(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    check_outputs("flush_prio", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);

    // ---- Asynchronous reset mid-run at Count=3 ----
    step(1'b1, 1'b0, 1'b0, 32'h0123_4567);
    step(1'b1, 1'b0, 1'b0, 32'h89AB_CDEF);
    step(1'b1, 1'b0, 1'b0, 32'h1357_9BDF);
    check_outputs("pre_async", 1'b1, 3'd3, 1'b0, 1'b0, 32'h0123_4567);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    #2;
    Reset = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    idle();
    @(negedge Clk);
    Reset = 1'b1;
    tick();
    check_outputs("async_release", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h2468_ACE0);
    check_outputs("resume_push", 1'b1, 3'd1, 1'b0, 1'b0, 32'h2468_ACE0);
    step(1'b0, 1'b1, 1'b0, 32'h0);

`ifdef INSTR_QUEUE_BYPASS_EN
    // ---- Same-cycle bypass consumed without storage ----
    drive(1'b1, 1'b1, 1'b0, 32'h2001_FFFF);
    #1;
    check("bypass.valid",  32'(Valid),  32'd1);
    check("bypass.opcode", 32'(Opcode), 32'h08);
    check("bypass.imm",    32'(Imm),    32'hFFFF);
    tick();
    idle();
    check_outputs("bypass_after", 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
